fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_queue.sv | 72 +++++++
 rtl/fetch_unit.sv | 76 +++++++
 tb/tb_fetch_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

   localparam int INST_W = 32;
   localparam logic [INST_W-1:0] NOP = 32'h00000013;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry {instruction, pc} queue; entry 0 is always the head.
// Flush beats push/pop; push while full is only accepted alongside a pop.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int AW = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [INST_W-1:0] push_inst,
   input  logic [AW-1:0]     push_pc,
   output logic [INST_W-1:0] head_inst,
   output logic [AW-1:0]     head_pc,
   output logic [1:0]        count
);

   logic [INST_W-1:0] inst0, inst1;
   logic [AW-1:0]     pc0, pc1;
   logic              do_pop, do_push;

   assign do_pop    = pop && (count != 2'd0);
   assign do_push   = push && ((count != 2'd2) || do_pop);
   assign head_inst = inst0;
   assign head_pc   = pc0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 2'd0;
         inst0 <= NOP;
         inst1 <= NOP;
         pc0   <= '0;
         pc1   <= '0;
      end else if (flush) begin
         count <= 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (count == 2'd0) begin
                  inst0 <= push_inst;
                  pc0   <= push_pc;
               end else begin
                  inst1 <= push_inst;
                  pc1   <= push_pc;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               inst0 <= inst1;
               pc0   <= pc1;
               count <= count - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged: the new word lands behind whatever survives the pop.
               if (count == 2'd1) begin
                  inst0 <= push_inst;
                  pc0   <= push_pc;
               end else begin
                  inst0 <= inst1;
                  pc0   <= pc1;
                  inst1 <= push_inst;
                  pc1   <= push_pc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC + BOOT/RUN/HALTED FSM feeding a 2-deep queue toward decode.
// A fetched word reaches the queue head one cycle later; fetch stalls when the queue is full and not popping.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int              NOAL     = 8,
   parameter logic [NOAL-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [NOAL-1:0]   imem_addr,
   input  logic [INST_W-1:0] imem_data,
   input  logic              redirect_valid,
   input  logic [NOAL-1:0]   redirect_pc,
   input  logic              halt_req,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst,
   output logic [NOAL-1:0]   inst_pc,
   input  logic              inst_ready,
   output logic              halted
);

   state_t          state, state_nxt;
   logic [NOAL-1:0] pc;
   logic [1:0]      count;
   logic            pop, fetch;

   assign imem_addr  = pc;
   assign inst_valid = (count != 2'd0);
   assign pop        = inst_valid && inst_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= BOOT;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (redirect_valid) begin
         state_nxt = RUN;
      end else begin
         case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (halt_req) state_nxt = HALTED;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = BOOT;
         endcase
      end
   end

   always_comb begin
      halted = (state == HALTED);
      fetch  = (state == RUN) && !halt_req && !redirect_valid &&
               ((count != 2'd2) || pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              pc <= RESET_PC;
      else if (redirect_valid) pc <= {redirect_pc[NOAL-1:2], 2'b00};
      else if (fetch)          pc <= pc + NOAL'(4);
   end

   fetch_queue #(.AW(NOAL)) u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fetch),
      .pop       (pop),
      .flush     (redirect_valid),
      .push_inst (imem_data),
      .push_pc   (pc),
      .head_inst (inst),
      .head_pc   (inst_pc),
      .count     (count)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit with a combinational pattern memory.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic [7:0]  imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic        halt_req;
   logic        inst_valid;
   logic [31:0] inst;
   logic [7:0]  inst_pc;
   logic        inst_ready;
   logic        halted;

   int checks   = 0;
   int failures = 0;

   fetch_unit #(.NOAL(8), .RESET_PC(8'h00)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready),
      .halted         (halted)
   );

   function automatic logic [31:0] mem_word(input logic [7:0] a);
      return {8'hC0, ~a, 8'h5A, a};
   endfunction

   assign imem_data = mem_word(imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       rdy;
      logic       redir;
      logic [7:0] rpc;
      logic       halt;
      logic       valid;
      logic [7:0] ipc;
      logic       hlt;
      logic [7:0] addr;
   } vec_t;

   localparam int NV = 27;
   vec_t vt [NV];

   function automatic vec_t mk(input logic rst, input logic rdy, input logic redir,
                               input logic [7:0] rpc, input logic halt, input logic valid,
                               input logic [7:0] ipc, input logic hlt, input logic [7:0] addr);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.halt = halt;
      v.valid = valid; v.ipc = ipc; v.hlt = hlt; v.addr = addr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input logic rst, input logic rdy, input logic redir,
                        input logic [7:0] rpc, input logic halt);
      @(negedge clk);
      rst_n          = rst;
      inst_ready     = rdy;
      redirect_valid = redir;
      redirect_pc    = rpc;
      halt_req       = halt;
      #1;
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [7:0] pc,
                             input logic h, input logic [7:0] a);
      chk({tag, " inst_valid"}, {31'h0, inst_valid}, {31'h0, v});
      chk({tag, " halted"}, {31'h0, halted}, {31'h0, h});
      chk({tag, " imem_addr"}, {24'h0, imem_addr}, {24'h0, a});
      if (v) begin
         chk({tag, " inst_pc"}, {24'h0, inst_pc}, {24'h0, pc});
         chk({tag, " inst"}, inst, mem_word(pc));
      end
   endtask

   initial begin
      rst_n = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
      redirect_pc = 8'h00; halt_req = 1'b0;

      // rst rdy redir rpc halt | valid ipc halted addr  (outputs seen before the next edge)
      vt[0]  = mk(0,1,0,8'h00,0, 0,8'h00,0,8'h00);
      vt[1]  = mk(1,1,0,8'h00,0, 0,8'h00,0,8'h00);
      vt[2]  = mk(1,1,0,8'h00,0, 0,8'h00,0,8'h00);
      vt[3]  = mk(1,1,0,8'h00,0, 1,8'h00,0,8'h04);
      vt[4]  = mk(1,1,0,8'h00,0, 1,8'h04,0,8'h08);
      vt[5]  = mk(1,0,0,8'h00,0, 1,8'h08,0,8'h0C);
      vt[6]  = mk(1,0,0,8'h00,0, 1,8'h08,0,8'h10);
      vt[7]  = mk(1,0,0,8'h00,0, 1,8'h08,0,8'h10);
      vt[8]  = mk(1,1,1,8'h41,0, 1,8'h08,0,8'h10);
      vt[9]  = mk(1,1,0,8'h00,0, 0,8'h00,0,8'h40);
      vt[10] = mk(1,1,0,8'h00,0, 1,8'h40,0,8'h44);
      vt[11] = mk(0,1,0,8'h00,0, 0,8'h00,0,8'h00);
      vt[12] = mk(1,1,0,8'h00,0, 0,8'h00,0,8'h00);
      vt[13] = mk(1,1,0,8'h00,0, 0,8'h00,0,8'h00);
      vt[14] = mk(1,1,0,8'h00,0, 1,8'h00,0,8'h04);
      vt[15] = mk(1,0,0,8'h00,0, 1,8'h04,0,8'h08);
      vt[16] = mk(1,0,0,8'h00,1, 1,8'h04,0,8'h0C);
      vt[17] = mk(1,1,0,8'h00,0, 1,8'h04,1,8'h0C);
      vt[18] = mk(1,1,0,8'h00,0, 1,8'h08,1,8'h0C);
      vt[19] = mk(1,1,0,8'h00,0, 0,8'h00,1,8'h0C);
      vt[20] = mk(1,1,1,8'h00,0, 0,8'h00,1,8'h0C);
      vt[21] = mk(1,1,0,8'h00,0, 0,8'h00,0,8'h00);
      vt[22] = mk(1,1,1,8'hFC,0, 1,8'h00,0,8'h04);
      vt[23] = mk(1,1,0,8'h00,0, 0,8'h00,0,8'hFC);
      vt[24] = mk(1,1,0,8'h00,0, 1,8'hFC,0,8'h00);
      vt[25] = mk(1,1,0,8'h00,0, 1,8'h00,0,8'h04);
      vt[26] = mk(1,0,0,8'h00,0, 1,8'h04,0,8'h08);

      for (int i = 0; i < NV; i++) begin
         apply(vt[i].rst, vt[i].rdy, vt[i].redir, vt[i].rpc, vt[i].halt);
         expect_out($sformatf("vec%0d", i), vt[i].valid, vt[i].ipc, vt[i].hlt, vt[i].addr);
         if (!vt[i].rst) begin
            chk($sformatf("vec%0d reset inst", i), inst, 32'h00000013);
            chk($sformatf("vec%0d reset inst_pc", i), {24'h0, inst_pc}, 32'h0);
         end
      end

      // Queue now holds 04 (head) and 08; assert reset between clock edges.
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async rst inst_valid", {31'h0, inst_valid}, 32'h0);
      chk("async rst inst", inst, 32'h00000013);
      chk("async rst inst_pc", {24'h0, inst_pc}, 32'h0);
      chk("async rst imem_addr", {24'h0, imem_addr}, 32'h0);
      chk("async rst halted", {31'h0, halted}, 32'h0);

      // Release with decode stalled: BOOT edge, then fetches until the queue is full.
      apply(1, 0, 0, 8'h00, 0);
      expect_out("rel boot", 0, 8'h00, 0, 8'h00);
      apply(1, 0, 0, 8'h00, 0);
      expect_out("rel run", 0, 8'h00, 0, 8'h00);
      apply(1, 0, 0, 8'h00, 0);
      expect_out("stall1", 1, 8'h00, 0, 8'h04);
      for (int k = 0; k < 4; k++) begin
         apply(1, 0, 0, 8'h00, 0);
         expect_out($sformatf("stall%0d", k + 2), 1, 8'h00, 0, 8'h08);
      end
      apply(1, 1, 0, 8'h00, 0);
      expect_out("drain0", 1, 8'h00, 0, 8'h08);
      apply(1, 1, 0, 8'h00, 0);
      expect_out("drain4", 1, 8'h04, 0, 8'h0C);
      apply(1, 1, 0, 8'h00, 0);
      expect_out("drain8", 1, 8'h08, 0, 8'h10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
